// File: rtl/cr_xp10_comp_mtf_enc.sv
// Compress-side move-to-front offset encoder.
// Replaces cached backref offsets with their MTF index.
module cr_xp10_comp_mtf_enc #(
    parameter int CACHE_DEPTH  = 4,
    parameter bit SUPPRESS_EOB = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cfg_xp10,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [3:0]  i_in_framing,
    input  logic        i_in_backref,
    input  logic [1:0]  i_in_lane,
    input  logic [15:0] i_in_offset,
    input  logic [31:0] i_in_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [3:0]  o_out_framing,
    output logic        o_out_backref,
    output logic        o_out_backref_type,
    output logic [1:0]  o_out_lane,
    output logic [7:0]  o_out_offset_msb,
    output logic [31:0] o_out_data
);

    typedef struct packed {
        logic [3:0]  framing;
        logic        backref;
        logic        btype;
        logic [1:0]  lane;
        logic [7:0]  msb;
        logic [31:0] data;
    } sym_t;

    logic [CACHE_DEPTH-1:0][15:0] r_cache;
    logic                         r_ptr_last;
    logic                         r_live;
    logic                         r_out_valid;
    logic                         r_skid_full;
    sym_t                         r_out;
    sym_t                         r_skid;

    logic [CACHE_DEPTH-1:0][15:0] w_cache_nx;
    logic [CACHE_DEPTH-1:0]       w_hit;
    logic [CACHE_DEPTH-1:0]       w_hit_eff;
    logic                         w_ptr_nx;
    logic                         w_acc;
    logic                         w_trailer;
    logic                         w_skew;
    logic                         w_any;
    logic [1:0]                   w_k;
    logic [1:0]                   w_idx;
    logic [2:0]                   w_cnt;
    logic                         w_last_lane;
    logic                         w_drop;
    logic                         w_emit;
    logic                         w_out_take;
    logic [7:0]                   w_byte;
    sym_t                         w_enc;

    assign o_in_ready  = r_live & ~r_skid_full & ~rst;
    assign w_acc       = i_in_valid & o_in_ready;
    assign w_trailer   = (i_in_framing == 4'hf);
    assign w_skew      = ~i_cfg_xp10 & r_ptr_last & (i_in_lane == 2'd0);
    assign w_out_take  = ~r_out_valid | i_out_ready;
    assign w_cnt       = (i_in_framing[2:0] == 3'd0) ? 3'd4 : i_in_framing[2:0];
    assign w_last_lane = ({1'b0, i_in_lane} + 3'd1) == w_cnt;
    assign w_idx       = w_skew ? (w_k - 2'd1) : w_k;
    assign w_emit      = w_acc & ~w_drop;

    // Cache lookup; under the XP9 skew entry 0 is not addressable.
    always_comb begin
        w_any = 1'b0;
        w_k   = 2'd0;
        for (int k = 0; k < CACHE_DEPTH; k++) begin
            w_hit[k] = (r_cache[k] == i_in_offset) && (r_cache[k] != 16'd0);
        end
        w_hit_eff = w_hit;
        if (w_skew) begin
            w_hit_eff[0] = 1'b0;
        end
        for (int k = CACHE_DEPTH - 1; k >= 0; k--) begin
            if (w_hit_eff[k]) begin
                w_any = 1'b1;
                w_k   = 2'(k);
            end
        end
    end

    // Build the outgoing symbol and decide whether it is dropped.
    always_comb begin
        w_enc         = '0;
        w_enc.framing = i_in_framing;
        w_enc.backref = i_in_backref;
        w_enc.lane    = i_in_lane;
        w_enc.data    = i_in_data;
        w_byte        = i_in_offset[7:0];
        w_drop        = 1'b0;
        if (!w_trailer) begin
            if (SUPPRESS_EOB) begin
                w_enc.framing[3] = 1'b0;
                w_drop = (w_enc.framing == 4'h0);
            end
            if (i_in_backref) begin
                if (w_any) begin
                    w_enc.btype = 1'b1;
                    w_byte      = {6'd0, w_idx};
                end else begin
                    w_enc.msb = i_in_offset[15:8];
                end
                w_enc.data[{i_in_lane, 3'b000} +: 8] = w_byte;
            end
        end
    end

    // Next cache contents and last-lane tracking for an accepted symbol.
    always_comb begin
        w_cache_nx = r_cache;
        w_ptr_nx   = 1'b0;
        if (w_trailer) begin
            w_cache_nx = '0;
        end else if (i_in_backref) begin
            w_ptr_nx = w_last_lane;
            for (int i = 1; i < CACHE_DEPTH; i++) begin
                if (!w_any || (i <= int'(w_k))) begin
                    w_cache_nx[i] = r_cache[i-1];
                end
            end
            w_cache_nx[0] = i_in_offset;
        end
    end

    // Cache state advances only on an accepted input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache    <= '0;
            r_ptr_last <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_acc) begin
                r_cache    <= w_cache_nx;
                r_ptr_last <= w_ptr_nx;
            end
        end
    end

    // Output register with a one-entry skid; skid always drains first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
            r_out       <= '0;
            r_skid      <= '0;
        end else if (w_out_take) begin
            if (r_skid_full) begin
                r_out       <= r_skid;
                r_out_valid <= 1'b1;
                r_skid_full <= 1'b0;
            end else if (w_emit) begin
                r_out       <= w_enc;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_emit) begin
            r_skid      <= w_enc;
            r_skid_full <= 1'b1;
        end
    end

    assign o_out_valid        = r_out_valid;
    assign o_out_framing      = r_out.framing;
    assign o_out_backref      = r_out.backref;
    assign o_out_backref_type = r_out.btype;
    assign o_out_lane         = r_out.lane;
    assign o_out_offset_msb   = r_out.msb;
    assign o_out_data         = r_out.data;

endmodule

// File: tb/tb_cr_xp10_comp_mtf_enc.sv
// Directed and stall-stress bench for the MTF encoder.
// A second instance covers the EOB suppression option.
module tb_cr_xp10_comp_mtf_enc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cfg;
    logic        in_valid, in_ready, in_br;
    logic [3:0]  in_f;
    logic [1:0]  in_lane;
    logic [15:0] in_off;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_br, out_ty;
    logic [3:0]  out_f;
    logic [1:0]  out_lane;
    logic [7:0]  out_msb;
    logic [31:0] out_data;

    logic        s_valid, s_ready, s_br;
    logic [3:0]  s_f;
    logic [1:0]  s_lane;
    logic [15:0] s_off;
    logic [31:0] s_data;
    logic        s_ovalid, s_obr, s_oty;
    logic [3:0]  s_of;
    logic [1:0]  s_olane;
    logic [7:0]  s_omsb;
    logic [31:0] s_odata;

    cr_xp10_comp_mtf_enc u_dut (
        .clk(clk), .rst(rst), .i_cfg_xp10(cfg),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_framing(in_f), .i_in_backref(in_br),
        .i_in_lane(in_lane), .i_in_offset(in_off),
        .i_in_data(in_data), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_framing(out_f),
        .o_out_backref(out_br), .o_out_backref_type(out_ty),
        .o_out_lane(out_lane), .o_out_offset_msb(out_msb),
        .o_out_data(out_data)
    );

    cr_xp10_comp_mtf_enc #(.SUPPRESS_EOB(1'b1)) u_sup (
        .clk(clk), .rst(rst), .i_cfg_xp10(1'b1),
        .i_in_valid(s_valid), .o_in_ready(s_ready),
        .i_in_framing(s_f), .i_in_backref(s_br),
        .i_in_lane(s_lane), .i_in_offset(s_off),
        .i_in_data(s_data), .o_out_valid(s_ovalid),
        .i_out_ready(1'b1), .o_out_framing(s_of),
        .o_out_backref(s_obr), .o_out_backref_type(s_oty),
        .o_out_lane(s_olane), .o_out_offset_msb(s_omsb),
        .o_out_data(s_odata)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] mk(logic [3:0] f, logic br, logic ty,
                                       logic [1:0] ln, logic [7:0] msb,
                                       logic [31:0] d);
        return {f, br, ty, ln, msb, d};
    endfunction

    logic [47:0] exp_q[$];
    logic [47:0] s_exp_q[$];
    logic [39:0] rec_q[$];
    logic [15:0] dc[4];
    bit          stress = 1'b0;
    bit          held_v = 1'b0;
    logic [47:0] held;

    always @(posedge clk) begin
        #2;
        if (stress) out_ready = ($urandom_range(0, 9) >= 3);
        else        out_ready = 1'b1;
    end

    // Output monitor: scoreboard in directed mode, MTF decoder in stress.
    always @(negedge clk) begin
        logic [47:0] got;
        logic [15:0] off;
        logic [39:0] rec;
        int kk;
        if (!rst) begin
            got = {out_f, out_br, out_ty, out_lane, out_msb, out_data};
            if (held_v) begin
                chk("hold", {15'd0, out_valid, got}, {15'd0, 1'b1, held});
                held_v = 1'b0;
            end
            if (out_valid && !out_ready) begin
                held   = got;
                held_v = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (!stress) begin
                    if (exp_q.size() == 0) chk("extra", 64'(exp_q.size()), 64'd1);
                    else chk("sym", 64'(got), 64'(exp_q.pop_front()));
                end else if (rec_q.size() == 0) begin
                    chk("stress_extra", 64'(rec_q.size()), 64'd1);
                end else begin
                    rec = rec_q.pop_front();
                    off = 16'd0;
                    if (out_br) begin
                        if (out_ty) begin
                            kk  = int'(out_data[1:0]);
                            off = dc[kk];
                        end else begin
                            kk  = 3;
                            off = {out_msb, out_data[7:0]};
                        end
                        for (int i = 3; i >= 1; i--)
                            if (i <= kk) dc[i] = dc[i-1];
                        dc[0] = off;
                    end
                    chk("stress", {24'd0, out_data[31:8], off},
                        {24'd0, rec[23:0], rec[39:24]});
                end
            end
            if (s_ovalid) begin
                if (s_exp_q.size() == 0) chk("s_extra", 64'(s_exp_q.size()), 64'd1);
                else chk("s_sym", 64'({s_of, s_obr, s_oty, s_olane, s_omsb, s_odata}),
                         64'(s_exp_q.pop_front()));
            end
        end
    end

    task automatic send(logic [3:0] f, logic br, logic [1:0] ln,
                        logic [15:0] off, logic [31:0] d);
        int t;
        @(negedge clk);
        in_valid = 1'b1; in_f = f; in_br = br;
        in_lane = ln; in_off = off; in_data = d;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic s_send(logic [3:0] f, logic br, logic [1:0] ln,
                          logic [15:0] off, logic [31:0] d);
        int t;
        @(negedge clk);
        s_valid = 1'b1; s_f = f; s_br = br;
        s_lane = ln; s_off = off; s_data = d;
        t = 0;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("s_accept", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic ex(logic [47:0] e);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() + rec_q.size() + s_exp_q.size()) != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(exp_q.size() + rec_q.size() + s_exp_q.size()), 64'd0);
    endtask

    localparam logic [31:0] D = 32'h11223344;

    initial begin
        logic [15:0] o;
        logic        b;
        rst = 1'b1; cfg = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_f = '0; in_br = 1'b0;
        in_lane = '0; in_off = '0; in_data = '0;
        s_valid = 1'b0; s_f = '0; s_br = 1'b0;
        s_lane = '0; s_off = '0; s_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        rst = 1'b0;
        #1 chk("ready_pre", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("ready_up", 64'(in_ready), 64'd1);
        chk("idle_valid", 64'(out_valid), 64'd0);

        ex(mk(4'h1, 1, 0, 0, 8'h00, 32'h11223364)); send(4'h1, 1, 0, 16'd100, D);
        ex(mk(4'h1, 1, 0, 0, 8'h00, 32'h112233C8)); send(4'h1, 1, 0, 16'd200, D);
        ex(mk(4'h1, 1, 1, 0, 8'h00, 32'h11223301)); send(4'h1, 1, 0, 16'd100, D);
        ex(mk(4'h1, 1, 1, 0, 8'h00, 32'h11223301)); send(4'h1, 1, 0, 16'd200, D);
        ex(mk(4'hf, 0, 0, 0, 8'h00, 32'hDEADBEEF)); send(4'hf, 0, 0, 16'd0, 32'hDEADBEEF);
        ex(mk(4'h1, 1, 0, 0, 8'h00, 32'h11223364)); send(4'h1, 1, 0, 16'd100, D);
        ex(mk(4'hf, 0, 0, 0, 8'h00, 32'h0BADF00D)); send(4'hf, 0, 0, 16'd0, 32'h0BADF00D);
        for (int i = 1; i <= 5; i++) begin
            ex(mk(4'h1, 1, 0, 0, 8'h00, {24'h112233, 8'(i)}));
            send(4'h1, 1, 0, 16'(i), D);
        end
        ex(mk(4'h1, 1, 1, 0, 8'h00, 32'h11223303)); send(4'h1, 1, 0, 16'd2, D);
        ex(mk(4'h1, 1, 0, 0, 8'h00, 32'h11223301)); send(4'h1, 1, 0, 16'd1, D);
        ex(mk(4'h3, 1, 0, 2, 8'h12, 32'h11343344)); send(4'h3, 1, 2, 16'h1234, D);
        ex(mk(4'h3, 1, 1, 2, 8'h00, 32'h11003344)); send(4'h3, 1, 2, 16'h1234, D);
        ex(mk(4'h4, 0, 0, 1, 8'h00, 32'hCAFEF00D)); send(4'h4, 0, 1, 16'h5555, 32'hCAFEF00D);
        ex(mk(4'h9, 1, 1, 0, 8'h00, 32'h11223300)); send(4'h9, 1, 0, 16'h1234, D);
        ex(mk(4'hf, 0, 0, 0, 8'h00, 32'h12345678)); send(4'hf, 0, 0, 16'd0, 32'h12345678);
        drain();

        cfg = 1'b0;
        ex(mk(4'h2, 1, 0, 1, 8'h00, 32'h11220744)); send(4'h2, 1, 1, 16'd7, D);
        ex(mk(4'h2, 1, 0, 0, 8'h00, 32'h11223307)); send(4'h2, 1, 0, 16'd7, D);
        ex(mk(4'h2, 1, 0, 1, 8'h00, 32'h11220944)); send(4'h2, 1, 1, 16'd9, D);
        ex(mk(4'h1, 1, 1, 0, 8'h00, 32'h11223300)); send(4'h1, 1, 0, 16'd7, D);
        ex(mk(4'hf, 0, 0, 0, 8'h00, 32'h0)); send(4'hf, 0, 0, 16'd0, 32'h0);
        drain();

        cfg = 1'b1;
        for (int i = 0; i < 4; i++) dc[i] = 16'd0;
        stress = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) == 0) @(negedge clk);
            b = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) o = 16'($urandom_range(1, 65535));
            else o = 16'($urandom_range(1, 6));
            rec_q.push_back({b ? o : 16'd0, 24'(i)});
            send(4'h1, b, 0, o, {24'(i), 8'h00});
        end
        drain();
        stress = 1'b0;

        s_send(4'h8, 1, 0, 16'd50, D);
        s_exp_q.push_back(mk(4'h1, 1, 1, 0, 8'h00, 32'h11223300));
        s_send(4'h1, 1, 0, 16'd50, D);
        s_exp_q.push_back(mk(4'h1, 0, 0, 0, 8'h00, 32'hA5A5A5A5));
        s_send(4'h9, 0, 0, 16'd0, 32'hA5A5A5A5);
        s_exp_q.push_back(mk(4'hf, 0, 0, 0, 8'h00, 32'h0BADCAFE));
        s_send(4'hf, 0, 0, 16'd0, 32'h0BADCAFE);
        s_exp_q.push_back(mk(4'h1, 1, 0, 0, 8'h00, 32'h11223332));
        s_send(4'h1, 1, 0, 16'd50, D);
        drain();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
